// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types for the round-robin mux arbiter: FSM state encoding and
// the select-width helper that keeps a single requester at a 1-bit select.
package rr_mux_arbiter_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } t_arb_state;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_rotating_pri_enc.sv
// Rotating priority encoder: first set request at or after ptr, wrapping
// modulo p_num_ports (works for non-power-of-two port counts).
module rotating_pri_enc #(
  parameter int p_num_ports = 4,
  parameter int p_sel_bits  = 2
) (
  input  logic [p_num_ports-1:0] req,
  input  logic [p_sel_bits-1:0]  ptr,
  output logic                   found,
  output logic [p_sel_bits-1:0]  idx,
  output logic [p_num_ports-1:0] onehot
);

  logic [2*p_num_ports-1:0] dbl_shifted;
  logic [p_num_ports-1:0]   rot;
  logic [p_sel_bits:0]      sum;

  // rot[k] is req[(ptr + k) mod N]; valid because ptr < N always holds.
  assign dbl_shifted = {req, req} >> ptr;
  assign rot         = dbl_shifted[p_num_ports-1:0];

  // NOTE: every output gets a default before the loop so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    // Scan from the far end so the nearest request to ptr is written last.
    for (int k = p_num_ports - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + (p_sel_bits + 1)'(k);
        if (sum >= (p_sel_bits + 1)'(p_num_ports))
          sum = sum - (p_sel_bits + 1)'(p_num_ports);
        idx = sum[p_sel_bits-1:0];
      end
    end
    onehot = found ? (p_num_ports'(1) << idx) : '0;
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving a downstream mux select; the grant is locked
// while a presented transfer is stalled so muxed data stays stable.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter  int p_num_ports = 4,
  localparam int p_sel_bits  = sel_width(p_num_ports)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [p_num_ports-1:0] req_val,
  output logic [p_num_ports-1:0] req_rdy,
  output logic                   out_val,
  input  logic                   out_rdy,
  output logic [p_sel_bits-1:0]  sel,
  output logic [p_num_ports-1:0] gnt
);

  t_arb_state                state, state_nxt;
  logic [p_sel_bits-1:0]     ptr, ptr_nxt;
  logic [p_sel_bits-1:0]     lock_sel, lock_sel_nxt;
  logic [p_num_ports-1:0]    lock_oh;
  logic                      win_found;
  logic [p_sel_bits-1:0]     win_idx;
  logic [p_num_ports-1:0]    win_oh;

  rotating_pri_enc #(
    .p_num_ports(p_num_ports),
    .p_sel_bits (p_sel_bits)
  ) u_enc (
    .req   (req_val),
    .ptr   (ptr),
    .found (win_found),
    .idx   (win_idx),
    .onehot(win_oh)
  );

  function automatic logic [p_sel_bits-1:0] wrap_inc(input logic [p_sel_bits-1:0] i);
    return (i == p_sel_bits'(p_num_ports - 1)) ? '0 : i + 1'b1;
  endfunction

  assign lock_oh = p_num_ports'(1) << lock_sel;

  // out_rdy only reaches req_rdy and next-state, never out_val/sel/gnt.
  always_comb begin
    out_val      = 1'b0;
    sel          = '0;
    gnt          = '0;
    req_rdy      = '0;
    state_nxt    = state;
    ptr_nxt      = ptr;
    lock_sel_nxt = lock_sel;
    unique case (state)
      ARB: begin
        if (win_found) begin
          out_val = 1'b1;
          sel     = win_idx;
          gnt     = win_oh;
          req_rdy = win_oh & {p_num_ports{out_rdy}};
          if (out_rdy) begin
            ptr_nxt = wrap_inc(win_idx);
          end else begin
            lock_sel_nxt = win_idx;
            state_nxt    = LOCK;
          end
        end
      end
      LOCK: begin
        sel     = lock_sel;
        out_val = |(req_val & lock_oh);
        gnt     = out_val ? lock_oh : '0;
        req_rdy = lock_oh & {p_num_ports{out_rdy}};
        if (out_val && out_rdy) begin
          ptr_nxt   = wrap_inc(lock_sel);
          state_nxt = ARB;
        end else if (!out_val) begin
          // Requester dropped valid mid-stall: release without a transfer.
          state_nxt = ARB;
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB;
      ptr      <= '0;
      lock_sel <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      lock_sel <= lock_sel_nxt;
    end
  end

endmodule
